xdma_grant_sender: RTL and testbench

- Downstream stage of the xDMA grant manager. Consumes its to-remote grant valid/ready handshake.
- Turns each accepted grant into one single-beat AXI write (AW/W/B) carrying a grant token to the previous hop's grant register.
- Tracks the write response, keeps a wrapping grant sequence number and flags error responses.

---
 rtl/xdma_grant_sender.sv | 98 +++++++++
 tb/tb_xdma_grant_sender.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/xdma_grant_sender.sv
// Sends each accepted grant as one single-beat AXI write of a grant token to the
// previous hop's grant register. Tracks the B response, the sequence number and a sticky error.
module xdma_grant_sender #(
  parameter int unsigned AddrWidth = 48,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned StrbWidth = DataWidth / 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 grant_valid_i,
  output logic                 grant_ready_o,
  input  logic [AddrWidth-1:0] prev_hop_grant_addr_i,
  output logic                 aw_valid_o,
  input  logic                 aw_ready_i,
  output logic [AddrWidth-1:0] aw_addr_o,
  output logic                 w_valid_o,
  input  logic                 w_ready_i,
  output logic [DataWidth-1:0] w_data_o,
  output logic [StrbWidth-1:0] w_strb_o,
  output logic                 w_last_o,
  input  logic                 b_valid_i,
  output logic                 b_ready_o,
  input  logic [1:0]           b_resp_i,
  output logic [7:0]           grant_seq_o,
  output logic                 busy_o,
  output logic                 error_o
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_B} state_e;

  state_e               state_q, state_d;
  logic [AddrWidth-1:0] addr_q;
  logic [7:0]           seq_q;
  logic                 aw_done_q, w_done_q, error_q;
  logic                 accept, aw_hs, w_hs, b_hs;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A channel counts as finished if it completed earlier or handshakes this cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant_valid_i) state_d = SEND;
      SEND:    if ((aw_done_q || aw_ready_i) && (w_done_q || w_ready_i)) state_d = WAIT_B;
      WAIT_B:  if (b_valid_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant_ready_o    = (state_q == IDLE);
    aw_valid_o       = (state_q == SEND) && !aw_done_q;
    w_valid_o        = (state_q == SEND) && !w_done_q;
    w_last_o         = w_valid_o;
    b_ready_o        = (state_q == WAIT_B);
    busy_o           = (state_q != IDLE);
    aw_addr_o        = addr_q;
    w_strb_o         = '1;
    w_data_o         = '0;
    w_data_o[0]      = 1'b1;
    w_data_o[15:8]   = seq_q;
    grant_seq_o      = seq_q;
    error_o          = error_q;
    accept           = grant_valid_i && grant_ready_o;
    aw_hs            = aw_valid_o && aw_ready_i;
    w_hs             = w_valid_o && w_ready_i;
    b_hs             = b_valid_i && b_ready_o;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q    <= '0;
      seq_q     <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      if (accept) begin
        addr_q    <= prev_hop_grant_addr_i;
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end
      if (aw_hs) aw_done_q <= 1'b1;
      if (w_hs)  w_done_q  <= 1'b1;
      if (b_hs) begin
        seq_q <= seq_q + 8'd1;
        if (b_resp_i != 2'b00) error_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_xdma_grant_sender.sv
// Bench for xdma_grant_sender: directed scenarios plus random AXI backpressure,
// checked every cycle against an obligation-based model of the grant write.
module tb_xdma_grant_sender;

  localparam int unsigned AW = 48;
  localparam int unsigned DW = 64;
  localparam int unsigned SW = DW / 8;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          grant_valid_i = 1'b0;
  logic          grant_ready_o;
  logic [AW-1:0] prev_hop_grant_addr_i = '0;
  logic          aw_valid_o;
  logic          aw_ready_i = 1'b0;
  logic [AW-1:0] aw_addr_o;
  logic          w_valid_o;
  logic          w_ready_i = 1'b0;
  logic [DW-1:0] w_data_o;
  logic [SW-1:0] w_strb_o;
  logic          w_last_o;
  logic          b_valid_i = 1'b0;
  logic          b_ready_o;
  logic [1:0]    b_resp_i = 2'b00;
  logic [7:0]    grant_seq_o;
  logic          busy_o;
  logic          error_o;

  xdma_grant_sender #(
    .AddrWidth(AW),
    .DataWidth(DW),
    .StrbWidth(SW)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .grant_valid_i(grant_valid_i), .grant_ready_o(grant_ready_o),
    .prev_hop_grant_addr_i(prev_hop_grant_addr_i),
    .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i), .aw_addr_o(aw_addr_o),
    .w_valid_o(w_valid_o), .w_ready_i(w_ready_i), .w_data_o(w_data_o),
    .w_strb_o(w_strb_o), .w_last_o(w_last_o),
    .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_resp_i(b_resp_i),
    .grant_seq_o(grant_seq_o), .busy_o(busy_o), .error_o(error_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad = 0;

  // Model: what the block still owes for the grant in flight.
  bit          owe_aw, owe_w, owe_b;
  logic [AW-1:0] m_addr;
  int          m_seq;
  bit          m_err;
  int          accepts = 0;
  int          w_beats = 0;
  logic [7:0]  tok_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_i) begin
    bit idle, b_rdy, do_acc, do_aw, do_w, do_b;
    if (!rst_ni) begin
      owe_aw = 0; owe_w = 0; owe_b = 0;
      m_addr = '0; m_seq = 0; m_err = 0;
    end
    idle  = !(owe_aw || owe_w || owe_b);
    b_rdy = owe_b && !owe_aw && !owe_w;
    check("grant_ready", 64'(grant_ready_o), 64'(idle));
    check("aw_valid", 64'(aw_valid_o), 64'(owe_aw));
    check("w_valid", 64'(w_valid_o), 64'(owe_w));
    check("w_last", 64'(w_last_o), 64'(owe_w));
    check("b_ready", 64'(b_ready_o), 64'(b_rdy));
    check("busy", 64'(busy_o), 64'(!idle));
    check("grant_seq", 64'(grant_seq_o), 64'(m_seq));
    check("error", 64'(error_o), 64'(m_err));
    check("w_strb", 64'(w_strb_o), 64'hFF);
    check("w_data", w_data_o, 64'(m_seq) * 64'd256 + 64'd1);
    if (owe_aw) check("aw_addr", 64'(aw_addr_o), 64'(m_addr));
    if (rst_ni) begin
      do_acc = idle && grant_valid_i;
      do_aw  = owe_aw && aw_ready_i;
      do_w   = owe_w && w_ready_i;
      do_b   = b_rdy && b_valid_i;
      if (do_w) begin
        tok_q.push_back(w_data_o[15:8]);
        w_beats++;
      end
      if (do_aw) owe_aw = 0;
      if (do_w)  owe_w = 0;
      if (do_b) begin
        owe_b = 0;
        m_seq = (m_seq + 1) % 256;
        if (b_resp_i != 2'b00) m_err = 1;
      end
      if (do_acc) begin
        owe_aw = 1; owe_w = 1; owe_b = 1;
        m_addr = prev_hop_grant_addr_i;
        accepts++;
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy_o && n < 50) begin
      step();
      n++;
    end
    if (busy_o) begin
      total++;
      bad++;
      $display("FAIL wait_idle: got busy=1 expected busy=0 within 50 cycles");
    end
  endtask

  task automatic send_grant(input logic [AW-1:0] a, input logic [1:0] r);
    aw_ready_i = 1; w_ready_i = 1; b_valid_i = 1; b_resp_i = r;
    prev_hop_grant_addr_i = a; grant_valid_i = 1;
    step();
    grant_valid_i = 0;
    wait_idle();
  endtask

  task automatic do_reset();
    rst_ni = 0;
    grant_valid_i = 0; aw_ready_i = 0; w_ready_i = 0; b_valid_i = 0; b_resp_i = 2'b00;
    step(); step();
    rst_ni = 1;
    step();
  endtask

  initial begin
    int acc0, beats0;
    logic [7:0] last_tok;
    step(); step();
    check("rst_aw_valid", 64'(aw_valid_o), 64'd0);
    check("rst_grant_ready", 64'(grant_ready_o), 64'd1);
    rst_ni = 1;
    step();

    // Grant held high for 10 cycles with zero-wait AXI: accepts every 3 cycles.
    tok_q.delete();
    acc0 = accepts;
    aw_ready_i = 1; w_ready_i = 1; b_valid_i = 1; b_resp_i = 2'b00;
    prev_hop_grant_addr_i = 48'h0000_2000_0000;
    grant_valid_i = 1;
    repeat (10) step();
    grant_valid_i = 0;
    wait_idle();
    check("held_accepts", 64'(accepts - acc0), 64'd4);
    check("held_tok_count", 64'(tok_q.size()), 64'd4);
    for (int i = 0; i < 4 && i < tok_q.size(); i++)
      check("held_tok", 64'(tok_q[i]), 64'(i));

    // Zero-wait single grant with exact cycle timing.
    do_reset();
    aw_ready_i = 1; w_ready_i = 1; b_valid_i = 1; b_resp_i = 2'b00;
    prev_hop_grant_addr_i = 48'h0000_1000_0040;
    grant_valid_i = 1;
    step();
    grant_valid_i = 0;
    @(negedge clk_i);
    check("zw_aw_valid", 64'(aw_valid_o), 64'd1);
    check("zw_w_valid", 64'(w_valid_o), 64'd1);
    check("zw_w_data", w_data_o, 64'h0001);
    check("zw_w_last", 64'(w_last_o), 64'd1);
    check("zw_aw_addr", 64'(aw_addr_o), 64'h1000_0040);
    check("zw_grant_ready_n1", 64'(grant_ready_o), 64'd0);
    @(negedge clk_i);
    check("zw_b_ready", 64'(b_ready_o), 64'd1);
    check("zw_grant_ready_n2", 64'(grant_ready_o), 64'd0);
    @(negedge clk_i);
    check("zw_seq", 64'(grant_seq_o), 64'd1);
    check("zw_grant_ready_n3", 64'(grant_ready_o), 64'd1);
    step();

    // Skewed channels: W completes immediately, AW stalls.
    beats0 = w_beats;
    aw_ready_i = 0; w_ready_i = 1; b_valid_i = 0;
    prev_hop_grant_addr_i = 48'hABCD_0000_1230;
    grant_valid_i = 1;
    step();
    grant_valid_i = 0;
    prev_hop_grant_addr_i = 48'h1111_2222_3333;
    step();
    for (int k = 0; k < 4; k++) begin
      check("skew_aw_valid", 64'(aw_valid_o), 64'd1);
      check("skew_w_valid", 64'(w_valid_o), 64'd0);
      check("skew_b_ready", 64'(b_ready_o), 64'd0);
      check("skew_addr", 64'(aw_addr_o), 64'hABCD_0000_1230);
      step();
    end
    aw_ready_i = 1;
    step();
    check("skew_wait_b", 64'(b_ready_o), 64'd1);
    b_valid_i = 1;
    wait_idle();
    check("skew_w_beats", 64'(w_beats - beats0), 64'd1);

    // Error response on the 2nd grant is sticky.
    do_reset();
    send_grant(48'h10, 2'b00);
    check("err_after_1", 64'(error_o), 64'd0);
    send_grant(48'h20, 2'b10);
    check("err_after_2", 64'(error_o), 64'd1);
    send_grant(48'h30, 2'b00);
    check("err_after_3", 64'(error_o), 64'd1);

    // Reset while AW done and W pending.
    aw_ready_i = 1; w_ready_i = 0; b_valid_i = 0;
    prev_hop_grant_addr_i = 48'h40;
    grant_valid_i = 1;
    step();
    grant_valid_i = 0;
    step();
    check("mid_aw_done", 64'(aw_valid_o), 64'd0);
    check("mid_w_pending", 64'(w_valid_o), 64'd1);
    rst_ni = 0;
    #1;
    check("mid_rst_w_valid", 64'(w_valid_o), 64'd0);
    check("mid_rst_b_ready", 64'(b_ready_o), 64'd0);
    step(); step();
    rst_ni = 1;
    step();
    check("mid_post_ready", 64'(grant_ready_o), 64'd1);
    check("mid_post_seq", 64'(grant_seq_o), 64'd0);
    check("mid_post_err", 64'(error_o), 64'd0);

    // Sequence wrap after 256 grants.
    for (int i = 0; i < 256; i++) send_grant(48'(i * 8), 2'b00);
    check("wrap_seq", 64'(grant_seq_o), 64'd0);
    send_grant(48'h800, 2'b00);
    last_tok = (tok_q.size() > 0) ? tok_q[$] : 8'hEE;
    check("wrap_tok257", 64'(last_tok), 64'd0);
    check("wrap_seq_after", 64'(grant_seq_o), 64'd1);

    // Random traffic and backpressure.
    for (int i = 0; i < 3000; i++) begin
      grant_valid_i = ($urandom_range(0, 3) != 0);
      prev_hop_grant_addr_i = 48'({$urandom(), $urandom()});
      aw_ready_i = 1'($urandom_range(0, 1));
      w_ready_i  = 1'($urandom_range(0, 1));
      b_valid_i  = ($urandom_range(0, 2) != 0);
      b_resp_i   = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      if (i == 1500) rst_ni = 0;
      if (i == 1503) rst_ni = 1;
      step();
    end
    grant_valid_i = 0; aw_ready_i = 1; w_ready_i = 1; b_valid_i = 1;
    wait_idle();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
